// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Miss sequencer states
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_RESUME    = 2'd3
  } state_e;

  // Default counter width and refill timeout (cycles spent in MISS_WAIT)
  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 256;

  // Bit positions inside a stall vector, shared with the pipeline top
  localparam int STALL_F = 0;
  localparam int STALL_D = 1;
  localparam int STALL_E = 2;
  localparam int STALL_M = 3;
  localparam int STALL_N = 4;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised event counter that sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after the enabled edge.
// Backpressure: none; en is sampled every cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment when enabled unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with D-cache miss refill FSM.
// Latency: stall/flush are same-cycle combinational; refill_req/counters/err are registered.
// Backpressure: refill_req is held until refill_gnt is sampled; the pipeline is frozen meanwhile.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_lu,
  input  logic             mem_access_M,
  input  logic             dcache_hit,
  input  logic             branch_taken_E,
  input  logic             refill_gnt,
  input  logic             refill_done,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             refill_req,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_count,
  output logic             err_timeout
);

  // Wait counter only needs to reach TIMEOUT-1
  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            refill_req_q, refill_req_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic            miss;
  logic            miss_start;
  logic            any_stall;
  logic [STALL_N-1:0] stall_vec;

  assign miss       = mem_access_M & ~dcache_hit;
  assign miss_start = (state_q == ST_RUN) & miss;

  // Stall/flush decode; a miss outranks a redirect, a redirect outranks load-use.
  // Outputs are forced low while reset is held so the pipe is released immediately.
  always_comb begin
    stall_vec = '0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (miss) begin
            stall_vec = '1;
          end else if (branch_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (hazard_lu) begin
            stall_vec[STALL_F] = 1'b1;
            stall_vec[STALL_D] = 1'b1;
            flush_E            = 1'b1;
          end
        end
        default: stall_vec = '1;
      endcase
    end
  end

  assign stall_F   = stall_vec[STALL_F];
  assign stall_D   = stall_vec[STALL_D];
  assign stall_E   = stall_vec[STALL_E];
  assign stall_M   = stall_vec[STALL_M];
  assign any_stall = |stall_vec;

  // Next-state, refill wait counter and sticky timeout flag
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (miss) state_d = ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        if (refill_gnt) state_d = refill_done ? ST_RESUME : ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (refill_done) begin
          state_d = ST_RESUME;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Keep waiting; the counter parks at its last value
          wait_cnt_d = wait_cnt_q;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    refill_req_d = (state_d == ST_MISS_REQ);
  end

  // FSM state and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      refill_req_q <= 1'b0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      refill_req_q <= refill_req_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  assign refill_req  = refill_req_q;
  assign err_timeout = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (any_stall),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (miss_start),
    .cnt   (miss_count)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with small counters and short timeout.
// Latency: inputs change 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: refill_gnt/refill_done driven directly by the stimulus.
module tb_pipe_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             hazard_lu, mem_access_M, dcache_hit, branch_taken_E;
  logic             refill_gnt, refill_done;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, refill_req, err_timeout;
  logic [CNT_W-1:0] stall_cycles, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_lu      (hazard_lu),
    .mem_access_M   (mem_access_M),
    .dcache_hit     (dcache_hit),
    .branch_taken_E (branch_taken_E),
    .refill_gnt     (refill_gnt),
    .refill_done    (refill_done),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .stall_M        (stall_M),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
    .refill_req     (refill_req),
    .stall_cycles   (stall_cycles),
    .miss_count     (miss_count),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stall vector as {M,E,D,F}; flush vector as {E,D}
  function automatic logic [31:0] stalls();
    return {28'd0, stall_M, stall_E, stall_D, stall_F};
  endfunction

  function automatic logic [31:0] flushes();
    return {30'd0, flush_E, flush_D};
  endfunction

  initial begin
    rst_n = 1'b0;
    hazard_lu = 1'b0; mem_access_M = 1'b0; dcache_hit = 1'b0; branch_taken_E = 1'b0;
    refill_gnt = 1'b0; refill_done = 1'b0;
    #2;
    check("rst_stalls", stalls(), 32'h0);
    check("rst_flush", flushes(), 32'h0);
    check("rst_req", 32'(refill_req), 32'h0);
    check("rst_scyc", 32'(stall_cycles), 32'h0);
    check("rst_mcnt", 32'(miss_count), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    #10 rst_n = 1'b1;

    // Load-use bubble
    cyc();
    hazard_lu = 1'b1; #1;
    check("lu_stalls", stalls(), 32'h3);
    check("lu_flush", flushes(), 32'h2);
    check("lu_scyc0", 32'(stall_cycles), 32'h0);
    cyc();
    hazard_lu = 1'b0; #1;
    check("lu_scyc1", 32'(stall_cycles), 32'h1);
    check("idle_stalls", stalls(), 32'h0);

    // Branch wins over load-use
    branch_taken_E = 1'b1; hazard_lu = 1'b1; #1;
    check("br_flush", flushes(), 32'h3);
    check("br_stalls", stalls(), 32'h0);
    cyc();
    branch_taken_E = 1'b0; hazard_lu = 1'b0; #1;
    check("br_scyc", 32'(stall_cycles), 32'h1);

    // Spurious handshake in RUN is ignored
    refill_gnt = 1'b1; refill_done = 1'b1; #1;
    check("spur_stalls", stalls(), 32'h0);
    cyc();
    refill_gnt = 1'b0; refill_done = 1'b0; #1;
    check("spur_req", 32'(refill_req), 32'h0);
    check("spur_mcnt", 32'(miss_count), 32'h0);

    // Miss with grant on 3rd request cycle, done on 5th wait cycle
    mem_access_M = 1'b1; dcache_hit = 1'b0; #1;
    check("miss_stalls", stalls(), 32'hF);
    check("miss_flush", flushes(), 32'h0);
    check("miss_req0", 32'(refill_req), 32'h0);
    cyc();
    #1;
    check("req1", 32'(refill_req), 32'h1);
    check("miss_cnt1", 32'(miss_count), 32'h1);
    check("req1_stalls", stalls(), 32'hF);
    cyc();
    #1;
    check("req2", 32'(refill_req), 32'h1);
    cyc();
    refill_gnt = 1'b1; #1;
    check("req3", 32'(refill_req), 32'h1);
    cyc();
    refill_gnt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) refill_done = 1'b1;
      #1;
      check("wait_req", 32'(refill_req), 32'h0);
      check("wait_stalls", stalls(), 32'hF);
      check("wait_err", 32'(err_timeout), 32'(i >= 5));
      cyc();
    end
    refill_done = 1'b0; dcache_hit = 1'b1; #1;
    check("resume_stalls", stalls(), 32'hF);
    check("resume_flush", flushes(), 32'h0);
    cyc();
    #1;
    check("run_stalls", stalls(), 32'h0);
    check("miss_scyc", 32'(stall_cycles), 32'd11);
    check("miss_cnt_hold", 32'(miss_count), 32'h1);

    // Drive stall_cycles past all-ones: 11 + 6 would wrap to 1
    hazard_lu = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    hazard_lu = 1'b0; #1;
    check("scyc_sat", 32'(stall_cycles), 32'd15);

    // Async reset in MISS_REQ
    dcache_hit = 1'b0; #1;
    cyc();
    #1;
    check("rreq_req", 32'(refill_req), 32'h1);
    check("rreq_mcnt", 32'(miss_count), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(refill_req), 32'h0);
    check("arst_stalls", stalls(), 32'h0);
    check("arst_scyc", 32'(stall_cycles), 32'h0);
    check("arst_mcnt", 32'(miss_count), 32'h0);
    check("arst_err", 32'(err_timeout), 32'h0);
    mem_access_M = 1'b0; dcache_hit = 1'b1;
    #1 rst_n = 1'b1;
    cyc();
    hazard_lu = 1'b1; #1;
    check("post_rst_run", stalls(), 32'h3);
    check("post_rst_req", 32'(refill_req), 32'h0);
    cyc();
    hazard_lu = 1'b0;

    // Branch frozen in EX across a miss; grant and done together
    mem_access_M = 1'b1; dcache_hit = 1'b0; branch_taken_E = 1'b1; #1;
    check("frz_miss_flush", flushes(), 32'h0);
    check("frz_miss_stalls", stalls(), 32'hF);
    cyc();
    refill_gnt = 1'b1; refill_done = 1'b1; #1;
    check("frz_req_flush", flushes(), 32'h0);
    check("frz_req", 32'(refill_req), 32'h1);
    cyc();
    refill_gnt = 1'b0; refill_done = 1'b0; dcache_hit = 1'b1; #1;
    check("frz_res_flush", flushes(), 32'h0);
    check("frz_res_stalls", stalls(), 32'hF);
    check("frz_res_req", 32'(refill_req), 32'h0);
    cyc();
    #1;
    check("frz_run_flush", flushes(), 32'h3);
    check("frz_run_stalls", stalls(), 32'h0);
    cyc();
    branch_taken_E = 1'b0; #1;
    check("frz_after_flush", flushes(), 32'h0);
    check("frz_scyc", 32'(stall_cycles), 32'd4);
    check("frz_mcnt", 32'(miss_count), 32'h1);

    // Refill timeout
    dcache_hit = 1'b0; #1;
    cyc();
    refill_gnt = 1'b1; #1;
    cyc();
    refill_gnt = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      check("to_err", 32'(err_timeout), 32'(i >= 5));
      check("to_stalls", stalls(), 32'hF);
      cyc();
    end
    refill_done = 1'b1; #1;
    check("to_err7", 32'(err_timeout), 32'h1);
    cyc();
    refill_done = 1'b0; dcache_hit = 1'b1; #1;
    check("to_resume_stalls", stalls(), 32'hF);
    check("to_resume_err", 32'(err_timeout), 32'h1);
    cyc();
    #1;
    check("to_run_stalls", stalls(), 32'h0);
    check("to_run_err", 32'(err_timeout), 32'h1);
    check("to_mcnt", 32'(miss_count), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
